// File: rtl/keypad_pkg.sv
// Shared types, row-drive constants and key decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [2:0] {
        SETTLE     = 3'd0,
        SAMPLE     = 3'd1,
        DB_PRESS   = 3'd2,
        ACCEPT     = 3'd3,
        DB_RELEASE = 3'd4
    } state_e;

    localparam logic [3:0] ROW0 = 4'b1110;
    localparam logic [3:0] ROW1 = 4'b1101;
    localparam logic [3:0] ROW2 = 4'b1011;
    localparam logic [3:0] ROW3 = 4'b0111;

    function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
        logic [3:0] r;
        case (row_idx)
            2'd0:    r = ROW0;
            2'd1:    r = ROW1;
            2'd2:    r = ROW2;
            default: r = ROW3;
        endcase
        return r;
    endfunction

    function automatic logic onehot4(input logic [3:0] col);
        return (col != 4'b0000) && ((col & (col - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] c;
        if (col[0])      c = 2'd0;
        else if (col[1]) c = 2'd1;
        else if (col[2]) c = 2'd2;
        else             c = 2'd3;
        return c;
    endfunction

    // Row 3 follows the physical legend F 0 E D, not hex order.
    function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [3:0] col);
        logic [3:0] k;
        case ({row_idx, col_index(col)})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hF;  4'hD: k = 4'h0;  4'hE: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan tick divider: one-clk tick pulse every TICK_DIV clocks.
module keypad_tick_gen #(
    parameter int unsigned TICK_DIV = 24000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row scan, press/release debounce and two-digit shift register for the 4x4 keypad.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 24000,
    parameter int unsigned SETTLE_TICKS = 2,
    parameter int unsigned DB_TICKS     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_sync,
    output logic [3:0] r_sel,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic [3:0] right_out,
    output logic [3:0] left_out
);

    localparam int unsigned SW = $clog2(SETTLE_TICKS + 1);
    localparam int unsigned DW = $clog2(DB_TICKS + 1);

    logic tick;

    keypad_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    state_e        state_q,     state_d;
    logic [1:0]    row_q,       row_d;
    logic [SW-1:0] set_cnt_q,   set_cnt_d;
    logic [DW-1:0] db_cnt_q,    db_cnt_d;
    logic [3:0]    cap_col_q,   cap_col_d;
    logic [3:0]    r_sel_q,     r_sel_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q,  key_code_d;
    logic          key_held_q,  key_held_d;
    logic [3:0]    right_q,     right_d;
    logic [3:0]    left_q,      left_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SETTLE;
            row_q       <= 2'd0;
            set_cnt_q   <= '0;
            db_cnt_q    <= '0;
            cap_col_q   <= 4'b0000;
            r_sel_q     <= ROW0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
            right_q     <= 4'h0;
            left_q      <= 4'h0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            set_cnt_q   <= set_cnt_d;
            db_cnt_q    <= db_cnt_d;
            cap_col_q   <= cap_col_d;
            r_sel_q     <= r_sel_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            right_q     <= right_d;
            left_q      <= left_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        set_cnt_d   = set_cnt_q;
        db_cnt_d    = db_cnt_q;
        cap_col_d   = cap_col_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        right_d     = right_q;
        left_d      = left_q;

        case (state_q)
            SETTLE: begin
                if (tick) begin
                    if (set_cnt_q == SW'(SETTLE_TICKS - 1)) begin
                        set_cnt_d = '0;
                        state_d   = SAMPLE;
                    end else begin
                        set_cnt_d = set_cnt_q + SW'(1);
                    end
                end
            end
            SAMPLE: begin
                if (tick) begin
                    if (onehot4(col_sync)) begin
                        cap_col_d = col_sync;
                        db_cnt_d  = '0;
                        state_d   = DB_PRESS;
                    end else begin
                        row_d   = row_q + 2'd1;
                        state_d = SETTLE;
                    end
                end
            end
            DB_PRESS: begin
                if (tick) begin
                    if (col_sync == cap_col_q) begin
                        if (db_cnt_q == DW'(DB_TICKS - 1)) begin
                            db_cnt_d = '0;
                            state_d  = ACCEPT;
                        end else begin
                            db_cnt_d = db_cnt_q + DW'(1);
                        end
                    end else begin
                        // Bounce: abandon this press and resume scanning.
                        db_cnt_d = '0;
                        row_d    = row_q + 2'd1;
                        state_d  = SETTLE;
                    end
                end
            end
            ACCEPT: begin
                key_valid_d = 1'b1;
                key_code_d  = keymap(row_q, cap_col_q);
                key_held_d  = 1'b1;
                left_d      = right_q;
                right_d     = key_code_d;
                db_cnt_d    = '0;
                state_d     = DB_RELEASE;
            end
            DB_RELEASE: begin
                // Any nonzero column, including a second key, restarts the release count.
                if (tick) begin
                    if (col_sync == 4'b0000) begin
                        if (db_cnt_q == DW'(DB_TICKS - 1)) begin
                            db_cnt_d   = '0;
                            key_held_d = 1'b0;
                            row_d      = row_q + 2'd1;
                            state_d    = SETTLE;
                        end else begin
                            db_cnt_d = db_cnt_q + DW'(1);
                        end
                    end else begin
                        db_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = SETTLE;
            end
        endcase

        r_sel_d = row_drive(row_d);
    end

    assign r_sel     = r_sel_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign right_out = right_q;
    assign left_out  = left_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a virtual keypad answers the row drive, and a key-level model tracks digits.
module tb_keypad_scan_ctrl;

    localparam int unsigned TD = 4;
    localparam int unsigned ST = 2;
    localparam int unsigned DB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] col_sync;
    logic [3:0] r_sel;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic [3:0] right_out;
    logic [3:0] left_out;

    keypad_scan_ctrl #(.TICK_DIV(TD), .SETTLE_TICKS(ST), .DB_TICKS(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .col_sync  (col_sync),
        .r_sel     (r_sel),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .right_out (right_out),
        .left_out  (left_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] row_pat [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] km [0:15] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hF, 4'h0, 4'hE, 4'hD};

    // Virtual keypad: a pressed key shows its column only while its row is driven.
    logic       press_en = 1'b0;
    logic [1:0] press_row = 2'd0;
    logic [3:0] press_col = 4'b0000;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'b0000;

    always_comb begin
        col_sync = 4'b0000;
        if (force_en) col_sync = force_val;
        else if (press_en && (r_sel == row_pat[press_row])) col_sync = press_col;
    end

    int         vcount = 0;
    logic [3:0] vcode = 4'h0;
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            vcount++;
            vcode = key_code;
        end
    end

    logic [3:0] right_m = 4'h0;
    logic [3:0] left_m  = 4'h0;

    typedef struct {
        int         row;
        int         col;
        int         hold;
        logic [3:0] code;
    } vec_t;
    vec_t vecs [0:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_row(input logic [3:0] pat, input bit equal);
        int n;
        n = 0;
        @(negedge clk);
        while (((r_sel == pat) != equal) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("wait_row_timeout", 32'(n), 32'(0));
    endtask

    task automatic check_outputs(input string name);
        check({name, "_key_code"}, key_code, vcode);
        check({name, "_right"}, right_out, right_m);
        check({name, "_left"}, left_out, left_m);
        check({name, "_held_off"}, key_held, 1'b0);
    endtask

    // Press one key for hold ticks, release for rel ticks; expect exactly one event.
    task automatic press_key(input string name, input int r, input int c,
                             input int hold, input int rel, input logic [3:0] exp);
        int v0;
        v0 = vcount;
        @(negedge clk);
        press_row = 2'(r);
        press_col = 4'(1 << c);
        press_en  = 1'b1;
        repeat (hold * TD) @(posedge clk);
        @(negedge clk);
        check({name, "_held_on"}, key_held, 1'b1);
        check({name, "_row_frozen"}, r_sel, row_pat[r]);
        press_en = 1'b0;
        repeat (rel * TD) @(posedge clk);
        @(negedge clk);
        check({name, "_events"}, 32'(vcount - v0), 32'(1));
        check({name, "_code"}, vcode, exp);
        left_m  = right_m;
        right_m = exp;
        check_outputs(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          v0;
        int          n;
        int          changes;
        int          dev;
        int          last_t;
        logic [3:0]  prev;
        logic [3:0]  seen_val [$];
        int          seen_t [$];

        vecs[0] = '{1, 2, 30, 4'h6};
        vecs[1] = '{3, 1, 30, 4'h0};
        vecs[2] = '{0, 0, 25, 4'h1};
        vecs[3] = '{2, 1, 35, 4'h8};
        vecs[4] = '{3, 3, 30, 4'hD};
        vecs[5] = '{3, 2, 28, 4'hE};
        vecs[6] = '{1, 3, 40, 4'hB};
        vecs[7] = '{3, 0, 30, 4'hF};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_r_sel", r_sel, 4'b1110);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_held", key_held, 1'b0);
        check("rst_right", right_out, 4'h0);
        check("rst_left", left_out, 4'h0);
        reset = 1'b1;

        // Idle scan: every row lasts SETTLE+1 ticks
        prev = r_sel;
        for (int t = 0; t < 70; t++) begin
            @(negedge clk);
            if (r_sel != prev) begin
                seen_val.push_back(r_sel);
                seen_t.push_back(t);
                prev = r_sel;
            end
        end
        check("scan_changes", 32'(seen_val.size() >= 4), 32'(1));
        if (seen_val.size() >= 4) begin
            check("scan_row1", seen_val[0], 4'b1101);
            check("scan_row2", seen_val[1], 4'b1011);
            check("scan_row3", seen_val[2], 4'b0111);
            check("scan_row0", seen_val[3], 4'b1110);
            for (int i = 1; i < 4; i++)
                check("scan_period", 32'(seen_t[i] - seen_t[i-1]), 32'((ST + 1) * TD));
        end
        check("scan_no_event", 32'(vcount), 32'(0));

        // Table-driven key presses
        for (int i = 0; i < 8; i++)
            press_key($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, vecs[i].hold, 15, vecs[i].code);

        // Release debounce: key_held drops DB ticks after release
        v0 = vcount;
        @(negedge clk);
        press_row = 2'd3; press_col = 4'b0010; press_en = 1'b1;
        repeat (30 * TD) @(posedge clk);
        #1 press_en = 1'b0;
        n = 0;
        while (key_held === 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("release_lower", 32'(n > int'((DB - 1) * TD)), 32'(1));
        check("release_upper", 32'(n <= int'(DB * TD)), 32'(1));
        repeat (10 * TD) @(posedge clk);
        @(negedge clk);
        check("release_events", 32'(vcount - v0), 32'(1));
        left_m = right_m; right_m = 4'h0;
        check_outputs("release");

        // Bouncing contact on row0/col3 must not produce an event
        v0 = vcount;
        wait_row(4'b1110, 1'b0);
        wait_row(4'b1110, 1'b1);
        press_row = 2'd0; press_col = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            press_en = ((i % 2) == 0);
            repeat (TD) @(negedge clk);
        end
        press_en = 1'b0;
        check("bounce_no_event", 32'(vcount - v0), 32'(0));
        press_key("bounce_stable", 0, 3, 30, 15, 4'hA);

        // Long hold on row2/col0: one event, row frozen
        v0 = vcount;
        dev = 0;
        @(negedge clk);
        press_row = 2'd2; press_col = 4'b0001; press_en = 1'b1;
        for (int t = 0; t < 100 * int'(TD); t++) begin
            @(negedge clk);
            if (vcount > v0 && r_sel != 4'b1011) dev++;
        end
        check("hold_one_event", 32'(vcount - v0), 32'(1));
        check("hold_code", vcode, 4'h7);
        check("hold_row_frozen", 32'(dev), 32'(0));
        check("hold_held_on", key_held, 1'b1);
        press_en = 1'b0;
        repeat (15 * TD) @(posedge clk);
        @(negedge clk);
        left_m = right_m; right_m = 4'h7;
        check_outputs("hold");

        // Randomized presses against the key-level model
        for (int i = 0; i < 10; i++) begin
            int r, c;
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            press_key($sformatf("rnd%0d", i), r, c, int'($urandom_range(25, 50)),
                      int'($urandom_range(10, 25)), km[r * 4 + c]);
        end

        // Two columns at once: rejected, scanning goes on
        v0 = vcount;
        changes = 0;
        force_en = 1'b1; force_val = 4'b0011;
        prev = r_sel;
        for (int t = 0; t < 60 * int'(TD); t++) begin
            @(negedge clk);
            if (r_sel != prev) changes++;
            prev = r_sel;
        end
        force_en = 1'b0;
        check("multi_no_event", 32'(vcount - v0), 32'(0));
        check("multi_scanning", 32'(changes >= 16), 32'(1));
        check("multi_digits", {24'h0, left_out, right_out}, {24'h0, left_m, right_m});

        // Reset in the middle of a press debounce
        v0 = vcount;
        wait_row(4'b1101, 1'b0);
        press_row = 2'd1; press_col = 4'b0001; press_en = 1'b1;
        wait_row(4'b1101, 1'b1);
        last_t = (ST + 2) * TD;
        repeat (last_t) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_r_sel", r_sel, 4'b1110);
        check("midrst_key_valid", key_valid, 1'b0);
        check("midrst_key_code", key_code, 4'h0);
        check("midrst_key_held", key_held, 1'b0);
        check("midrst_right", right_out, 4'h0);
        check("midrst_left", left_out, 4'h0);
        repeat (5) @(negedge clk);
        press_en = 1'b0;
        reset = 1'b1;
        repeat (30 * TD) @(negedge clk);
        check("midrst_no_event", 32'(vcount - v0), 32'(0));
        right_m = 4'h0; left_m = 4'h0;
        check("midrst_digits", {24'h0, left_out, right_out}, {24'h0, left_m, right_m});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Sequencing controller for the 4x4 keypad path. It drives the active-low row selects and waits a settle time on each row. It debounces both press and release on the synchronized columns, then emits exactly one key event per physical press. Each accepted key code shifts into the two-digit (left/right) register that feeds the display multiplexer.

Parameters:
TICK_DIV, 24000, clk cycles per scan tick (24000 = 0.5 ms at 48 MHz); must be >= 2
SETTLE_TICKS, 2, ticks a row is driven before its columns are sampled; must be >= 1
DB_TICKS, 10, consecutive stable ticks required to accept a press or a release; must be >= 1

Ports:
clk  input  1  system clock (the single clock)
reset  input  1  asynchronous, active-low reset
col_sync  input  4  synchronized column inputs; active-high; bit0 = leftmost column
r_sel  output  4  row drive, active-low one-hot; 4'b1110 = row0
key_valid  output  1  one-cycle pulse when a press is accepted
key_code  output  4  hex code of the last accepted key; valid when key_valid is high, held afterwards
key_held  output  1  high from press acceptance until release acceptance
right_out  output  4  most recent accepted digit
left_out  output  4  previous accepted digit

Behaviour:
- Reset (asynchronous, reset==0):
  - r_sel=4'b1110, key_valid=0, key_code=0, key_held=0, right_out=0, left_out=0.
  - State=SETTLE, row index=0, tick divider=0, counters=0.
- Tick: an internal divider asserts tick for 1 clk every TICK_DIV clks. All timing counts ticks; key_valid is the only clk-granular output.
- Valid pattern: col_sync has exactly one bit set. Zero or multiple bits set count as "not pressed".
- FSM states:
  - SETTLE: drive current row. After SETTLE_TICKS ticks go to SAMPLE.
  - SAMPLE (on next tick):
    - valid pattern: latch it into cap_col, clear db_cnt, go to DB_PRESS.
    - otherwise: advance row (0->1->2->3->0), go to SETTLE.
  - DB_PRESS (each tick):
    - col_sync==cap_col: db_cnt++. When it reaches DB_TICKS go to ACCEPT.
    - otherwise: advance row, go to SETTLE (bounce rejected, no event).
  - ACCEPT (1 clk, not tick-gated):
    - key_valid=1, key_code=map(row,cap_col), key_held<=1.
    - left_out<=right_out, right_out<=code.
    - Go to DB_RELEASE with db_cnt=0.
  - DB_RELEASE (each tick, row held):
    - col_sync==0: db_cnt++, else db_cnt=0.
    - When db_cnt reaches DB_TICKS: key_held<=0, advance row, go to SETTLE.
- Row is held constant in DB_PRESS, ACCEPT and DB_RELEASE.
- Keymap (row: col0 col1 col2 col3):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: F 0 E D
- Key 0 is a real key: code 4'h0 shifts in like any other. There is no zero-suppression.
- Holding a key produces exactly one key_valid. No auto-repeat.
- A second key pressed while one is held keeps DB_RELEASE from completing: the pattern is nonzero. No event is generated until all keys are released.
- Latency: from a stable press seen at SAMPLE, key_valid fires DB_TICKS ticks later plus 1 clk.
- Reset mid-operation: immediate return to reset values. A pending debounce is discarded and no event is emitted.
- Counters are sized with $clog2(param+1) and saturate; no wrap.

Decomposition:
- keypad_pkg:
  - state enum {SETTLE, SAMPLE, DB_PRESS, ACCEPT, DB_RELEASE}
  - row drive constants ROW0..ROW3 (1110, 1101, 1011, 0111)
  - function keymap(row_idx[1:0], col[3:0]) -> [3:0]
  - function onehot4(col) -> bit
- Sub-module keypad_tick_gen(clk, reset, tick): parameterized TICK_DIV divider.

Test Plan:
- Reset with col_sync=0 -> r_sel cycles 1110,1101,1011,0111,1110, each row held SETTLE_TICKS+1 ticks; key_valid never asserts.
- TICK_DIV=4, DB_TICKS=3; assert col_sync=4'b0100 only while r_sel=1101 and keep it stable -> one key_valid, key_code=6, right_out=6, left_out=0.
- Then press row3/col1 and release -> key_code=0, right_out=0, left_out=6; key_held falls DB_TICKS ticks after release.
- Press row0/col3 with col toggling every tick for 2 ticks, then stable -> no event during the toggling; exactly one key_valid (code A) after stabilization.
- Hold row2/col0 for 100 ticks -> exactly one key_valid (code 7); r_sel stays 1011 throughout.
- Assert col_sync=4'b0011 on any row -> no event and scanning continues; pull reset low mid-DB_PRESS -> all outputs return to reset values immediately, no key_valid.
